// File: rtl/mc_controller.sv
// Multi-cycle RISC-V style main controller.
// Moore FSM sequencing fetch/decode/execute/writeback, with memory-handshake
// stalls on MemReady and a sticky trap state for unsupported opcodes.
module mc_controller (
  input  logic       clk,
  input  logic       reset,
  input  logic [6:0] op,
  input  logic       Zero,
  input  logic       MemReady,
  output logic       PCWrite,
  output logic       AdrSrc,
  output logic       IRWrite,
  output logic       RegWrite,
  output logic       MemWrite,
  output logic [1:0] ALUSrcA,
  output logic [1:0] ALUSrcB,
  output logic [1:0] ResultSrc,
  output logic [1:0] ALUOp,
  output logic [1:0] ImmSrc,
  output logic       Illegal,
  output logic       InstrDone,
  output logic [3:0] State
);

  localparam logic [6:0] OpLoad  = 7'b0000011;
  localparam logic [6:0] OpStore = 7'b0100011;
  localparam logic [6:0] OpRType = 7'b0110011;
  localparam logic [6:0] OpIType = 7'b0010011;
  localparam logic [6:0] OpJal   = 7'b1101111;
  localparam logic [6:0] OpBeq   = 7'b1100011;

  typedef enum logic [3:0] {
    StFetch    = 4'd0,
    StDecode   = 4'd1,
    StMemAdr   = 4'd2,
    StMemRead  = 4'd3,
    StMemWb    = 4'd4,
    StMemWrite = 4'd5,
    StExecuteR = 4'd6,
    StExecuteI = 4'd7,
    StAluWb    = 4'd8,
    StJal      = 4'd9,
    StBeq      = 4'd10,
    StIllegal  = 4'd15
  } state_e;

  state_e state_q, state_d;

  // Raw (pre-reset-gating) control values decoded from the current state.
  logic       pc_update;
  logic       branch;
  logic       ir_write_raw;
  logic       reg_write_raw;
  logic       mem_write_raw;
  logic       instr_done_raw;

  // State register; reset forces FETCH immediately.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= StFetch;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StFetch: begin
        if (MemReady) state_d = StDecode;
      end
      StDecode: begin
        case (op)
          OpLoad, OpStore: state_d = StMemAdr;
          OpRType:         state_d = StExecuteR;
          OpIType:         state_d = StExecuteI;
          OpJal:           state_d = StJal;
          OpBeq:           state_d = StBeq;
          default:         state_d = StIllegal;
        endcase
      end
      StMemAdr: begin
        state_d = (op == OpLoad) ? StMemRead : StMemWrite;
      end
      StMemRead: begin
        if (MemReady) state_d = StMemWb;
      end
      StMemWb:    state_d = StFetch;
      StMemWrite: begin
        if (MemReady) state_d = StFetch;
      end
      StExecuteR: state_d = StAluWb;
      StExecuteI: state_d = StAluWb;
      StAluWb:    state_d = StFetch;
      StJal:      state_d = StAluWb;
      StBeq:      state_d = StFetch;
      StIllegal:  state_d = StIllegal;
      // Unused encodings cannot be reached; recover to FETCH if ever seen.
      default:    state_d = StFetch;
    endcase
  end

  // Per-state datapath controls; everything defaults to 0.
  always_comb begin
    AdrSrc         = 1'b0;
    ALUSrcA        = 2'b00;
    ALUSrcB        = 2'b00;
    ResultSrc      = 2'b00;
    ALUOp          = 2'b00;
    Illegal        = 1'b0;
    pc_update      = 1'b0;
    branch         = 1'b0;
    ir_write_raw   = 1'b0;
    reg_write_raw  = 1'b0;
    mem_write_raw  = 1'b0;
    instr_done_raw = 1'b0;
    case (state_q)
      StFetch: begin
        ir_write_raw = MemReady;
        ALUSrcB      = 2'b10;
        ResultSrc    = 2'b10;
        pc_update    = MemReady;
      end
      StDecode: begin
        ALUSrcA = 2'b01;
        ALUSrcB = 2'b01;
      end
      StMemAdr: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
      end
      StMemRead: begin
        AdrSrc = 1'b1;
      end
      StMemWb: begin
        ResultSrc      = 2'b01;
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
      end
      StMemWrite: begin
        // Held steady while the memory stalls; completion only on MemReady.
        AdrSrc         = 1'b1;
        mem_write_raw  = 1'b1;
        instr_done_raw = MemReady;
      end
      StExecuteR: begin
        ALUSrcA = 2'b10;
        ALUOp   = 2'b10;
      end
      StExecuteI: begin
        ALUSrcA = 2'b10;
        ALUSrcB = 2'b01;
        ALUOp   = 2'b10;
      end
      StAluWb: begin
        reg_write_raw  = 1'b1;
        instr_done_raw = 1'b1;
      end
      StJal: begin
        ALUSrcA   = 2'b01;
        ALUSrcB   = 2'b10;
        pc_update = 1'b1;
      end
      StBeq: begin
        ALUSrcA        = 2'b10;
        ALUOp          = 2'b01;
        branch         = 1'b1;
        instr_done_raw = 1'b1;
      end
      StIllegal: begin
        Illegal = 1'b1;
      end
      default: begin
      end
    endcase
  end

  // Immediate format follows op directly in every state.
  always_comb begin
    ImmSrc = 2'b00;
    case (op)
      OpStore: ImmSrc = 2'b01;
      OpBeq:   ImmSrc = 2'b10;
      OpJal:   ImmSrc = 2'b11;
      default: ImmSrc = 2'b00;
    endcase
  end

  // Write enables are gated by reset so MemReady cannot leak through FETCH.
  always_comb begin
    PCWrite   = reset & (pc_update | (branch & Zero));
    IRWrite   = reset & ir_write_raw;
    RegWrite  = reset & reg_write_raw;
    MemWrite  = reset & mem_write_raw;
    InstrDone = reset & instr_done_raw;
  end

  assign State = state_q;

endmodule

// File: tb/tb_mc_controller.sv
module tb_mc_controller;

  logic       clk = 1'b0;
  logic       reset;
  logic [6:0] op;
  logic       Zero;
  logic       MemReady;
  logic       PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, Illegal, InstrDone;
  logic [1:0] ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc;
  logic [3:0] State;

  typedef struct packed {
    logic [3:0] st;
    logic       pcw, adr, irw, rw, mw;
    logic [1:0] asa, asb, rs, aop, imm;
    logic       ill, done;
  } out_t;

  localparam int KLw = 0, KSw = 1, KR = 2, KI = 3, KJal = 4, KBeq = 5, KIll = 6;
  localparam int KAbortRd = 7, KAbortWr = 8;

  out_t       exp_q[$];
  int         tests = 0;
  int         failed = 0;
  int         cyc = 0;
  logic [6:0] cur_op;
  logic       done_flag = 1'b0;

  mc_controller dut (
    .clk       (clk),
    .reset     (reset),
    .op        (op),
    .Zero      (Zero),
    .MemReady  (MemReady),
    .PCWrite   (PCWrite),
    .AdrSrc    (AdrSrc),
    .IRWrite   (IRWrite),
    .RegWrite  (RegWrite),
    .MemWrite  (MemWrite),
    .ALUSrcA   (ALUSrcA),
    .ALUSrcB   (ALUSrcB),
    .ResultSrc (ResultSrc),
    .ALUOp     (ALUOp),
    .ImmSrc    (ImmSrc),
    .Illegal   (Illegal),
    .InstrDone (InstrDone),
    .State     (State)
  );

  always #5 clk = ~clk;

  function automatic logic is_legal(input logic [6:0] o);
    return o inside {7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1101111, 7'b1100011};
  endfunction

  function automatic out_t model(input int st, input logic mr, input logic z, input logic rst,
                                 input logic [6:0] o);
    out_t r;
    logic pcu, br;
    r = '0;
    pcu = 1'b0;
    br = 1'b0;
    r.st = st[3:0];
    case (o)
      7'b0100011: r.imm = 2'b01;
      7'b1100011: r.imm = 2'b10;
      7'b1101111: r.imm = 2'b11;
      default:    r.imm = 2'b00;
    endcase
    case (st)
      0:  begin r.irw = mr; r.asb = 2'b10; r.rs = 2'b10; pcu = mr; end
      1:  begin r.asa = 2'b01; r.asb = 2'b01; end
      2:  begin r.asa = 2'b10; r.asb = 2'b01; end
      3:  r.adr = 1'b1;
      4:  begin r.rs = 2'b01; r.rw = 1'b1; r.done = 1'b1; end
      5:  begin r.adr = 1'b1; r.mw = 1'b1; r.done = mr; end
      6:  begin r.asa = 2'b10; r.aop = 2'b10; end
      7:  begin r.asa = 2'b10; r.asb = 2'b01; r.aop = 2'b10; end
      8:  begin r.rw = 1'b1; r.done = 1'b1; end
      9:  begin r.asa = 2'b01; r.asb = 2'b10; pcu = 1'b1; end
      10: begin r.asa = 2'b10; r.aop = 2'b01; br = 1'b1; r.done = 1'b1; end
      15: r.ill = 1'b1;
      default: ;
    endcase
    r.pcw = pcu | (br & z);
    if (!rst) begin
      r.pcw = 1'b0; r.irw = 1'b0; r.rw = 1'b0; r.mw = 1'b0; r.done = 1'b0;
    end
    return r;
  endfunction

  // zsel: 0/1 forces Zero, 2 randomizes it.
  task automatic cycle(input int st, input logic mr, input logic rst, input int zsel = 2);
    logic z;
    @(posedge clk);
    #1;
    z = (zsel == 2) ? 1'($urandom_range(0, 1)) : 1'(zsel);
    op = cur_op;
    reset = rst;
    MemReady = mr;
    Zero = z;
    exp_q.push_back(model(st, mr, z, rst, cur_op));
  endtask

  task automatic rnd_cycle(input int st);
    cycle(st, 1'($urandom_range(0, 1)), 1'b1);
  endtask

  task automatic stall(input int st, input int n);
    repeat (n) cycle(st, 1'b0, 1'b1);
    cycle(st, 1'b1, 1'b1);
  endtask

  task automatic reset_pulse();
    cycle(0, 1'($urandom_range(0, 1)), 1'b0);
    cycle(0, 1'b0, 1'b1);
  endtask

  task automatic run_instr(input int kind, input int fs, input int ms, input int zsel,
                           input logic [6:0] ill_op);
    case (kind)
      KLw, KAbortRd:         cur_op = 7'b0000011;
      KSw, KAbortWr:         cur_op = 7'b0100011;
      KR:                    cur_op = 7'b0110011;
      KI:                    cur_op = 7'b0010011;
      KJal:                  cur_op = 7'b1101111;
      KBeq:                  cur_op = 7'b1100011;
      default:               cur_op = ill_op;
    endcase
    stall(0, fs);
    rnd_cycle(1);
    case (kind)
      KLw:      begin rnd_cycle(2); stall(3, ms); rnd_cycle(4); end
      KSw:      begin rnd_cycle(2); stall(5, ms); end
      KR:       begin rnd_cycle(6); rnd_cycle(8); end
      KI:       begin rnd_cycle(7); rnd_cycle(8); end
      KJal:     begin rnd_cycle(9); rnd_cycle(8); end
      KBeq:     cycle(10, 1'($urandom_range(0, 1)), 1'b1, zsel);
      KIll:     begin repeat (10) rnd_cycle(15); reset_pulse(); end
      KAbortRd: begin rnd_cycle(2); repeat (ms) cycle(3, 1'b0, 1'b1); reset_pulse(); end
      default:  begin rnd_cycle(2); repeat (ms) cycle(5, 1'b0, 1'b1); reset_pulse(); end
    endcase
  endtask

  always @(negedge clk) begin
    out_t a, e;
    cyc <= cyc + 1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      a = {State, PCWrite, AdrSrc, IRWrite, RegWrite, MemWrite, ALUSrcA, ALUSrcB,
           ResultSrc, ALUOp, ImmSrc, Illegal, InstrDone};
      tests++;
      if (a !== e) begin
        failed++;
        $display("FAIL outputs cycle %0d state: got %0d want %0d | vector got %h want %h",
                 cyc, a.st, e.st, a, e);
      end
    end
  end

  // Watchdog: the stimulus must complete within a bounded time.
  initial begin
    #2000000;
    if (!done_flag) begin
      failed++;
      $display("FAIL expired wait: stimulus did not complete in time");
      $display("[TB] %0d tests run, %0d failed", tests, failed);
      $finish;
    end
  end

  initial begin
    logic [6:0] iop;
    int kind;
    reset = 1'b0;
    op = 7'd0;
    cur_op = 7'd0;
    Zero = 1'b0;
    MemReady = 1'b0;
    cycle(0, 1'b1, 1'b0);
    #1;
    tests++;
    if (State !== 4'd0 || PCWrite !== 1'b0 || IRWrite !== 1'b0 || RegWrite !== 1'b0 ||
        MemWrite !== 1'b0 || InstrDone !== 1'b0 || Illegal !== 1'b0) begin
      failed++;
      $display("FAIL reset state: State=%0d PCWrite=%b IRWrite=%b RegWrite=%b MemWrite=%b",
               State, PCWrite, IRWrite, RegWrite, MemWrite);
    end
    cycle(0, 1'b0, 1'b1);
    run_instr(KLw, 0, 0, 2, 7'd0);
    run_instr(KSw, 0, 3, 2, 7'd0);
    run_instr(KBeq, 0, 0, 1, 7'd0);
    run_instr(KBeq, 1, 0, 0, 7'd0);
    run_instr(KJal, 0, 0, 2, 7'd0);
    run_instr(KR, 2, 0, 2, 7'd0);
    run_instr(KI, 0, 0, 2, 7'd0);
    run_instr(KIll, 0, 0, 2, 7'b1111111);
    run_instr(KAbortRd, 0, 1, 2, 7'd0);
    run_instr(KLw, 1, 2, 2, 7'd0);
    run_instr(KAbortWr, 0, 2, 2, 7'd0);
    for (int n = 0; n < 300; n++) begin
      kind = $urandom_range(0, 8);
      do iop = 7'($urandom_range(0, 127)); while (is_legal(iop));
      run_instr(kind, $urandom_range(0, 3), $urandom_range(0, 3), 2, iop);
    end
    @(posedge clk);
    @(posedge clk);
    done_flag = 1'b1;
    tests++;
    if (exp_q.size() != 0) begin
      failed++;
      $display("FAIL expired wait: %0d expectations never compared", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule

// File: doc/mc_controller.md
MC_CONTROLLER -- requirements
Module: mc_controller

Interface
REQ-001 SHALL have port: clk  input  1  single clock; all state updates on rising edge.
REQ-002 SHALL have port: reset  input  1  asynchronous, active-low reset; reset=0 resets the block.
REQ-003 SHALL have port: op  input  7  opcode field of the instruction register.
REQ-004 SHALL have port: Zero  input  1  ALU zero flag.
REQ-005 SHALL have port: MemReady  input  1  memory completes the current access this cycle.
REQ-006 SHALL have port: PCWrite  output  1  PC register enable.
REQ-007 SHALL have port: AdrSrc  output  1  memory address select: 0=PC, 1=ALUOut.
REQ-008 SHALL have ports: IRWrite, RegWrite, MemWrite  output  1 each  write enables.
REQ-009 SHALL have ports: ALUSrcA, ALUSrcB, ResultSrc, ALUOp, ImmSrc  output  2 each  datapath selects.
REQ-010 SHALL have port: Illegal  output  1  unsupported opcode trapped.
REQ-011 SHALL have port: InstrDone  output  1  one-cycle pulse on the last cycle of each instruction.
REQ-012 SHALL have port: State  output  4  current state code, for debug.

Function
REQ-013 SHALL implement a Moore FSM with these codes: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, JAL=9, BEQ=10, ILLEGAL=15.
REQ-014 SHALL transition FETCH->DECODE when MemReady=1 and hold FETCH otherwise.
REQ-015 SHALL transition DECODE on op: 0000011 or 0100011 ->MEMADR, 0110011->EXECUTER, 0010011->EXECUTEI, 1101111->JAL, 1100011->BEQ, any other value ->ILLEGAL.
REQ-016 SHALL transition MEMADR->MEMREAD if op=0000011, and ->MEMWRITE otherwise.
REQ-017 SHALL transition MEMREAD->MEMWB and MEMWRITE->FETCH only when MemReady=1, and hold otherwise.
REQ-018 SHALL transition MEMWB->FETCH, EXECUTER/EXECUTEI->ALUWB, JAL->ALUWB, ALUWB->FETCH and BEQ->FETCH unconditionally; ILLEGAL SHALL hold until reset.
REQ-019 SHALL drive every output not listed for a state as 0 (never X).
REQ-020 SHALL drive in FETCH: AdrSrc=0, IRWrite=MemReady, ALUSrcA=00, ALUSrcB=10, ALUOp=00, ResultSrc=10, PCUpdate=MemReady.
REQ-021 SHALL drive in DECODE: ALUSrcA=01, ALUSrcB=01, ALUOp=00.
REQ-022 SHALL drive in MEMADR: ALUSrcA=10, ALUSrcB=01, ALUOp=00.
REQ-023 SHALL drive in MEMREAD: AdrSrc=1, ResultSrc=00.
REQ-024 SHALL drive in MEMWB: ResultSrc=01, RegWrite=1.
REQ-025 SHALL drive in MEMWRITE: AdrSrc=1, ResultSrc=00, MemWrite=1, held constant until MemReady=1.
REQ-026 SHALL drive in EXECUTER: ALUSrcA=10, ALUSrcB=00, ALUOp=10.
REQ-027 SHALL drive in EXECUTEI: ALUSrcA=10, ALUSrcB=01, ALUOp=10.
REQ-028 SHALL drive in ALUWB: ResultSrc=00, RegWrite=1.
REQ-029 SHALL drive in JAL: ALUSrcA=01, ALUSrcB=10, ALUOp=00, ResultSrc=00, PCUpdate=1.
REQ-030 SHALL drive in BEQ: ALUSrcA=10, ALUSrcB=00, ALUOp=01, ResultSrc=00, Branch=1.
REQ-031 SHALL drive Illegal=1 only in ILLEGAL.
REQ-032 SHALL compute PCWrite = PCUpdate | (Branch & Zero), combinationally.
REQ-033 SHALL derive ImmSrc combinationally from op in every state: 0000011/0010011->00, 0100011->01, 1100011->10, 1101111->11, other->00.
REQ-034 SHALL assert InstrDone for one cycle in MEMWB, ALUWB, BEQ, and in MEMWRITE when MemReady=1.
REQ-035 SHALL not latch op; op changes are visible only through the DECODE/MEMADR branch decisions.

Reset
REQ-036 SHALL, while reset=0, force state to FETCH immediately and asynchronously, and force PCWrite, IRWrite, RegWrite, MemWrite and InstrDone to 0 regardless of MemReady.
REQ-037 SHALL, when reset is asserted mid-instruction (any state, including a stalled MEMWRITE), abandon that instruction and begin FETCH on the first rising edge after reset=1.

Verification
REQ-038 SHALL verify lw with MemReady=1: state sequence 0,1,2,3,4,0; RegWrite=1 only in state 4; InstrDone pulses once.
REQ-039 SHALL verify sw with MemReady=0 for 3 cycles in MEMWRITE: state stays 5 for 4 cycles, MemWrite=1 throughout, InstrDone=1 only on the MemReady=1 cycle.
REQ-040 SHALL verify beq in state 10: Zero=1 gives PCWrite=1; Zero=0 gives PCWrite=0; then state 0.
REQ-041 SHALL verify jal: states 0,1,9,8,0; PCWrite=1 in 9; ImmSrc=11; RegWrite=1 in 8.
REQ-042 SHALL verify op=1111111 in DECODE: state 15, Illegal=1 and all enables 0 held for 10 cycles; reset pulse returns the FSM to state 0.
REQ-043 SHALL verify reset driven low in MEMREAD with MemReady=0: State=0 and all enables 0 before the next clock edge.
